mult_result_buffer: RTL and testbench
=====================================

Name: mult_result_buffer

Overview:
- Downstream stage of the registered floating-point multiplier wrapper.
- Captures the wrapper's result stream (valid + 32-bit single-precision data, no backpressure) into a FIFO.
- Classifies each result (NaN, infinity, zero, subnormal) on entry and presents results to a consumer over a valid/ready handshake.
- Reports occupancy and a sticky overflow flag, because the multiplier cannot be stalled.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- WIDTH, 32, data width; fixed single-precision layout (1/8/23), so only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- valid_in  input  1  result valid from multiplier wrapper
- data_in  input  32  FP32 result from multiplier wrapper
- out_valid  output  1  head entry available
- out_ready  input  1  consumer accepts head entry
- out_data  output  32  head entry data
- out_flags  output  4  head entry class {nan, inf, zero, subnormal}, bit 3 = nan
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a valid_in result was dropped
- clear_overflow  input  1  synchronous clear of overflow

Behaviour:
- Reset (reset=0, asynchronous): read/write pointers, count and overflow go to 0, so out_valid=0. out_data and out_flags are don't-care while out_valid=0. Storage contents are not reset.
- Reset mid-operation: all queued entries are discarded, and the first push after release behaves as into an empty FIFO.
- FIFO is first-word-fall-through:
  - out_valid = (count != 0).
  - out_data and out_flags reflect the head entry combinationally from storage.
- Push: valid_in=1 at edge N.
  - The entry is written and count increments.
  - If the FIFO was empty, out_valid=1 from cycle N+1.
  - Latency input to output is 1 cycle.
- Pop: happens at an edge where out_valid=1 and out_ready=1. The read pointer advances and count decrements.
- out_ready=1 while out_valid=0 has no effect.
- Simultaneous push and pop:
  - Count is unchanged and both pointers advance.
  - This is allowed when full: the pop frees a slot and the push is accepted.
  - This is allowed when count=1.
- Full (count=DEPTH) with valid_in=1 and no pop: the data is dropped, storage and pointers are unchanged, and overflow is set at that edge.
- Empty with valid_in=1 and out_ready=1: push only. There is no bypass, and the entry appears the next cycle.
- overflow behaviour:
  - Stays set until a clk edge with clear_overflow=1.
  - If a drop and a clear occur at the same edge, set wins.
- Pointers are $clog2(DEPTH)+1 bits wide. Full/empty is determined by MSB difference with equal low bits, and wrap-around is natural modulo 2*DEPTH.
- count is a registered value, consistent with the pointers every cycle.
- Classification is computed on data_in at push and stored alongside the data (36-bit entries). Fields are exp = data[30:23] and man = data[22:0]:
  - nan = (exp==8'hFF) && (man!=0)
  - inf = (exp==8'hFF) && (man==0)
  - zero = (exp==0) && (man==0), either sign
  - subnormal = (exp==0) && (man!=0)
  - At most one flag is set, and none for normal numbers.
- Sign is carried in data only.

Decomposition:
- Package fp32_pkg holds:
  - constants FP32_EXP_MSB/LSB, FP32_MAN_MSB, FP32_EXP_ALL_ONES
  - packed struct fp_class_t {nan, inf, zero, subnormal}
  - function fp32_classify(logic [31:0]) returning fp_class_t
- One sub-module, sync_fifo_fwft (params DEPTH, W), containing pointers, count, storage, push/pop/full/empty logic.
- mult_result_buffer instantiates it with W=36 and adds classification plus the overflow register.

Test Plan:
- Reset release, then push 32'h3F800000 (1.0) at cycle 1 with out_ready=0 -> out_valid=1 at cycle 2, out_data=32'h3F800000, out_flags=4'b0000, count=1.
- Push 32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h00000001 back-to-back, then drain with out_ready=1 -> data returned in order, flags 1000, 0100, 0010, 0001; count ends at 0 and out_valid=0.
- Fill DEPTH=8 entries with 0x1..0x8, then push 0x9 with out_ready=0 -> count stays 8, overflow=1, drained sequence is 0x1..0x8.
- Full FIFO, valid_in=1 with data 0xA and out_ready=1 in the same cycle -> count stays 8, overflow stays 0, 0xA is the last entry drained.
- overflow=1, then clear_overflow=1 on the same edge as another dropped push -> overflow remains 1; clear on the next edge with no drop -> overflow=0.
- Reset pulled low asynchronously mid-cycle with count=5 -> count=0, out_valid=0, overflow=0 immediately; after release, push 0x3F800000 -> it is the first entry out.

Source files
------------

// File: rtl/fp32_pkg.sv
// FP32 field layout, per-result classification and the buffered entry format.
package fp32_pkg;

    localparam int FP32_EXP_MSB = 30;
    localparam int FP32_EXP_LSB = 23;
    localparam int FP32_MAN_MSB = 22;
    localparam logic [7:0] FP32_EXP_ALL_ONES = 8'hFF;

    // Field order puts nan in bit 3 and subnormal in bit 0.
    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic subnormal;
    } fp_class_t;

    // One buffered result: class flags above the raw 32-bit pattern.
    typedef struct packed {
        fp_class_t   cls;
        logic [31:0] data;
    } fp_entry_t;

    // At most one flag is set; normal numbers set none. Sign is ignored.
    function automatic fp_class_t fp32_classify(input logic [31:0] value);
        logic [7:0]            exp_f;
        logic [FP32_MAN_MSB:0] man_f;
        fp_class_t             cls;
        exp_f         = value[FP32_EXP_MSB:FP32_EXP_LSB];
        man_f         = value[FP32_MAN_MSB:0];
        cls.nan       = (exp_f == FP32_EXP_ALL_ONES) && (man_f != '0);
        cls.inf       = (exp_f == FP32_EXP_ALL_ONES) && (man_f == '0);
        cls.zero      = (exp_f == '0) && (man_f == '0);
        cls.subnormal = (exp_f == '0) && (man_f != '0);
        return cls;
    endfunction

endpackage

// File: rtl/mult_result_buffer_if.sv
// Producer/consumer/status signals of the multiplier result buffer.
interface mult_result_buffer_if #(
    parameter int DEPTH = 8
) ();
    logic                     valid_in;
    logic [31:0]              data_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_data;
    logic [3:0]               out_flags;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     clear_overflow;

    // Environment side: drives the multiplier stream and the consumer ready.
    modport master (
        output valid_in, data_in, out_ready, clear_overflow,
        input  out_valid, out_data, out_flags, count, overflow
    );

    // Buffer side.
    modport slave (
        input  valid_in, data_in, out_ready, clear_overflow,
        output out_valid, out_data, out_flags, count, overflow
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO. Pointers carry one extra wrap bit
// so full and empty are distinguished without a separate flag.
module sync_fifo_fwft #(
    parameter int DEPTH = 8,
    parameter int W     = 36
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_valid,
    input  logic [W-1:0]            push_data,
    input  logic                    pop_ready,
    output logic                    pop_valid,
    output logic [W-1:0]            pop_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    dropped
);
    localparam int         AW  = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]  count_q, count_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         full;
    logic         do_push;
    logic         do_pop;

    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_valid = (count_q != '0);
    assign do_pop    = pop_valid && pop_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push   = push_valid && (!full || do_pop);
    assign dropped   = push_valid && !do_push;
    assign pop_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign count     = count_q;

    // Next-state pointers and occupancy.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers alone define valid contents.
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mult_result_buffer.sv
// Buffers the multiplier result stream, tagging each result with its FP32
// class on entry, and flags any result lost because the buffer was full.
module mult_result_buffer
    import fp32_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32   // single-precision layout only; 32 is the sole legal value
) (
    input  logic                 clk,
    input  logic                 reset,
    mult_result_buffer_if.slave  bus
);
    fp_entry_t wr_entry;
    fp_entry_t rd_entry;
    logic      dropped;
    logic      overflow_q, overflow_d;

    assign wr_entry.cls  = fp32_classify(bus.data_in[WIDTH-1:0]);
    assign wr_entry.data = bus.data_in;

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .W     ($bits(fp_entry_t))
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (bus.valid_in),
        .push_data  (wr_entry),
        .pop_ready  (bus.out_ready),
        .pop_valid  (bus.out_valid),
        .pop_data   (rd_entry),
        .count      (bus.count),
        .dropped    (dropped)
    );

    assign bus.out_data  = rd_entry.data;
    assign bus.out_flags = rd_entry.cls;
    assign bus.overflow  = overflow_q;

    // Sticky overflow: a drop sets it and outranks a simultaneous clear.
    always_comb begin
        overflow_d = overflow_q;
        if (dropped)                 overflow_d = 1'b1;
        else if (bus.clear_overflow) overflow_d = 1'b0;
    end

    // Overflow register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

endmodule

// File: tb/tb_mult_result_buffer.sv
// Randomized plus directed bench for mult_result_buffer with a queue-based
// reference model and a decoupled scoreboard monitor.
module tb_mult_result_buffer;
    localparam int DEPTH = 8;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    mult_result_buffer_if #(.DEPTH(DEPTH)) bus ();

    mult_result_buffer #(.DEPTH(DEPTH), .WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state: expected entries in order, occupancy and sticky flag.
    logic [35:0] exp_q[$];
    int          model_cnt = 0;
    logic        model_ovf = 1'b0;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Class flags straight from the field definitions {nan, inf, zero, subnormal}.
    function automatic logic [3:0] ref_flags(input logic [31:0] v);
        logic [7:0]  e;
        logic [22:0] m;
        e = v[30:23];
        m = v[22:0];
        if (e == 8'hFF) return (m != 0) ? 4'b1000 : 4'b0100;
        if (e == 8'h00) return (m == 0) ? 4'b0010 : 4'b0001;
        return 4'b0000;
    endfunction

    // Reference model: decides push/pop/drop from the buffer rules at each edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            model_cnt = 0;
            model_ovf = 1'b0;
        end else begin
            bit pop, push_ok;
            pop     = (model_cnt > 0) && bus.out_ready;
            push_ok = bus.valid_in && ((model_cnt < DEPTH) || pop);
            if (push_ok) exp_q.push_back({ref_flags(bus.data_in), bus.data_in});
            model_cnt = model_cnt + int'(push_ok) - int'(pop);
            if (bus.valid_in && !push_ok) model_ovf = 1'b1;
            else if (bus.clear_overflow)  model_ovf = 1'b0;
        end
    end

    // Monitor: mid-cycle status checks, and pops/compares on each handshake.
    always @(negedge clk) begin
        if (reset) begin
            check("out_valid", 36'(bus.out_valid), 36'(model_cnt != 0));
            check("count", 36'(bus.count), 36'(model_cnt));
            check("overflow", 36'(bus.overflow), 36'(model_ovf));
            if (model_cnt != 0 && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 36'(1), 36'(0));
                end else begin
                    logic [35:0] e;
                    e = exp_q.pop_front();
                    check("head_entry", {bus.out_flags, bus.out_data}, e);
                end
            end
        end
    end

    // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic c);
        bus.valid_in       = v;
        bus.data_in        = d;
        bus.out_ready      = r;
        bus.clear_overflow = c;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH; i++) begin
            if (model_cnt == 0) break;
            drive(1'b0, 32'h0, 1'b1, 1'b0);
        end
        check("drain_done", 36'(model_cnt), 36'(0));
        check("drain_count", 36'(bus.count), 36'(0));
        check("drain_valid", 36'(bus.out_valid), 36'(0));
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic fill_seq();
        for (int i = 1; i <= DEPTH; i++) drive(1'b1, 32'(i), 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_fp();
        logic        s;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom_range(1, 23'h7FFFFF));
        case ($urandom_range(0, 5))
            0:       return {s, 8'hFF, m};
            1:       return {s, 8'hFF, 23'h0};
            2:       return {s, 8'h00, 23'h0};
            3:       return {s, 8'h00, m};
            default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid_in = 1'b0; bus.data_in = '0; bus.out_ready = 1'b0; bus.clear_overflow = 1'b0;
        reset = 1'b0;
        #23;
        check("reset_count", 36'(bus.count), 36'(0));
        check("reset_valid", 36'(bus.out_valid), 36'(0));
        check("reset_overflow", 36'(bus.overflow), 36'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        // Single push of 1.0 appears one cycle later with no flags.
        drive(1'b1, 32'h3F800000, 1'b0, 1'b0);
        check("one_valid", 36'(bus.out_valid), 36'(1));
        check("one_entry", {bus.out_flags, bus.out_data}, {4'b0000, 32'h3F800000});
        check("one_count", 36'(bus.count), 36'(1));
        drain();

        // Special values back-to-back.
        drive(1'b1, 32'h7FC00000, 1'b0, 1'b0);
        check("nan_flags", 36'(bus.out_flags), 36'(4'b1000));
        drive(1'b1, 32'h7F800000, 1'b0, 1'b0);
        drive(1'b1, 32'h80000000, 1'b0, 1'b0);
        drive(1'b1, 32'h00000001, 1'b0, 1'b0);
        check("special_count", 36'(bus.count), 36'(4));
        drain();

        // Overflow on full, then clear.
        fill_seq();
        drive(1'b1, 32'h9, 1'b0, 1'b0);
        check("full_count", 36'(bus.count), 36'(DEPTH));
        check("full_overflow", 36'(bus.overflow), 36'(1));
        drain();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        check("clear_overflow", 36'(bus.overflow), 36'(0));

        // Full with simultaneous push and pop: accepted, no overflow.
        fill_seq();
        drive(1'b1, 32'hA, 1'b1, 1'b0);
        check("fullpp_count", 36'(bus.count), 36'(DEPTH));
        check("fullpp_overflow", 36'(bus.overflow), 36'(0));
        drain();

        // Drop beats a same-edge clear; a later clear succeeds.
        fill_seq();
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 1'b0, 1'b1);
        check("set_wins", 36'(bus.overflow), 36'(1));
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        check("clear_after", 36'(bus.overflow), 36'(0));

        // Asynchronous reset with five entries queued and overflow set.
        drive(1'b1, 32'hD, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("pre_reset_count", 36'(bus.count), 36'(5));
        bus.out_ready = 1'b0;
        #3 reset = 1'b0;
        #1;
        check("async_count", 36'(bus.count), 36'(0));
        check("async_valid", 36'(bus.out_valid), 36'(0));
        check("async_overflow", 36'(bus.overflow), 36'(0));
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 32'h3F800000, 1'b0, 1'b0);
        check("post_reset_head", 36'(bus.out_data), 36'(32'h3F800000));
        check("post_reset_count", 36'(bus.count), 36'(1));
        drain();

        // Randomized traffic; scoreboard checks every handshake.
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 9) < 6), rand_fp(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
        end
        drain();
        check("scoreboard_empty", 36'(exp_q.size()), 36'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
